varredura_matriz_leds: RTL and testbench



---
 rtl/varredura_matriz_leds.sv | 143 ++++++++++++++
 tb/tb_varredura_matriz_leds.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/varredura_matriz_leds.sv
// Column-scanned 5x7 LED matrix driver: one lit column at a time, a blank cycle between columns,
// and a one-cycle pulse at the end of each frame. Define CURSOR_BLINK_EN to add a blinking cursor overlay.
module varredura_matriz_leds #(
   parameter int DIV_SCAN     = 1000,
   parameter int BLINK_FRAMES = 25
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] matriz0,
   input  logic [6:0] matriz1,
   input  logic [6:0] matriz2,
   input  logic [6:0] matriz3,
   input  logic [6:0] matriz4,
   input  logic [2:0] coordColuna,
   input  logic [2:0] coordLinha,
   output logic [4:0] colunas,
   output logic [6:0] linhas,
   output logic       fim_varredura
);

   localparam int            PW     = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(DIV_SCAN - 1);

   logic [PW-1:0] p_q, p_d;
   logic [2:0]    c_q, c_d;
   logic [4:0]    colunas_q, colunas_d;
   logic [6:0]    linhas_q, linhas_d;
   logic          fim_q, fim_d;
   logic [6:0]    pixel;
   logic          frame_end;

`ifdef CURSOR_BLINK_EN
   localparam int            FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] frame_q, frame_d;
   logic          blink_q, blink_d;
`else
   logic          unused_coord;
   assign unused_coord = ^{coordColuna, coordLinha};
`endif

   // Pixel word of the active column, with the cursor bit flipped during the blink-on phase
   always_comb begin
      pixel = 7'b0000000;
      case (c_q)
         3'd0:    pixel = matriz0;
         3'd1:    pixel = matriz1;
         3'd2:    pixel = matriz2;
         3'd3:    pixel = matriz3;
         3'd4:    pixel = matriz4;
         default: pixel = 7'b0000000;
      endcase
`ifdef CURSOR_BLINK_EN
      if (blink_q && (coordColuna == c_q) && (coordColuna <= 3'd4) && (coordLinha <= 3'd6)) begin
         pixel = pixel ^ (7'b0000001 << coordLinha);
      end else begin
         pixel = pixel;
      end
`endif
   end

   // Scan sequencing: lit cycles while the prescaler runs, then one blank cycle and advance
   always_comb begin
      p_d       = '0;
      c_d       = 3'd0;
      colunas_d = 5'b11111;
      linhas_d  = 7'b0000000;
      fim_d     = 1'b0;
      frame_end = 1'b0;
      if (!enable) begin
         p_d = '0;
         c_d = 3'd0;
      end else if (p_q == P_LAST) begin
         p_d       = '0;
         c_d       = (c_q == 3'd4) ? 3'd0 : c_q + 3'd1;
         fim_d     = (c_q == 3'd4);
         frame_end = (c_q == 3'd4);
      end else begin
         p_d       = p_q + {{(PW-1){1'b0}}, 1'b1};
         c_d       = c_q;
         colunas_d = ~(5'b00001 << c_q);
         linhas_d  = pixel;
      end
   end

`ifdef CURSOR_BLINK_EN
   // The blink phase flips on the same edge that emits the BLINK_FRAMES-th end-of-frame pulse
   always_comb begin
      frame_d = frame_q;
      blink_d = blink_q;
      if (!enable) begin
         frame_d = '0;
         blink_d = 1'b0;
      end else if (frame_end) begin
         if (frame_q == F_LAST) begin
            frame_d = '0;
            blink_d = ~blink_q;
         end else begin
            frame_d = frame_q + {{(FW-1){1'b0}}, 1'b1};
            blink_d = blink_q;
         end
      end else begin
         frame_d = frame_q;
         blink_d = blink_q;
      end
   end

   // Blink state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_q <= '0;
         blink_q <= 1'b0;
      end else begin
         frame_q <= frame_d;
         blink_q <= blink_d;
      end
   end
`endif

   // Scan state and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         p_q       <= '0;
         c_q       <= 3'd0;
         colunas_q <= 5'b11111;
         linhas_q  <= 7'b0000000;
         fim_q     <= 1'b0;
      end else begin
         p_q       <= p_d;
         c_q       <= c_d;
         colunas_q <= colunas_d;
         linhas_q  <= linhas_d;
         fim_q     <= fim_d;
      end
   end

   assign colunas       = colunas_q;
   assign linhas        = linhas_q;
   assign fim_varredura = fim_q;

endmodule

// File: tb/tb_varredura_matriz_leds.sv
// Self-checking bench for varredura_matriz_leds: reset/start vectors, frame timing, enable drop,
// live update, cursor blink (when CURSOR_BLINK_EN is defined) and a randomized run against a scan model.
module tb_varredura_matriz_leds;

   localparam int DIV = 4;
   localparam int BF  = 2;

   logic       clock = 1'b0;
   logic       reset, enable;
   logic [6:0] m0, m1, m2, m3, m4;
   logic [2:0] cc, cl;
   logic [4:0] colunas;
   logic [6:0] linhas;
   logic       fim;

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;   // enabled edges since the scan (re)started
   int fim_at[$];
   logic [4:0] slot_cols[$];

   typedef struct {
      logic       rst;
      logic       en;
      logic [4:0] col;
      logic [6:0] lin;
      logic       fim;
   } vec_t;
   vec_t vec[11];

   always #5 clock = ~clock;

   varredura_matriz_leds #(.DIV_SCAN(DIV), .BLINK_FRAMES(BF)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .matriz0(m0), .matriz1(m1), .matriz2(m2), .matriz3(m3), .matriz4(m4),
      .coordColuna(cc), .coordLinha(cl),
      .colunas(colunas), .linhas(linhas), .fim_varredura(fim)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
      end
   endtask

   function automatic logic [6:0] word(input int col);
      case (col)
         0:       return m0;
         1:       return m1;
         2:       return m2;
         3:       return m3;
         default: return m4;
      endcase
   endfunction

   // One clock: predict from the cycle position in the frame, then compare after the edge
   task automatic step();
      logic [4:0] ec;
      logic [6:0] el;
      logic       ef;
      int slot, ph, col, fr;
      @(posedge clock);
      if (reset || !enable) begin
         k = 0; ec = 5'b11111; el = 7'd0; ef = 1'b0;
      end else begin
         slot = k / DIV; ph = k % DIV; col = slot % 5; fr = slot / 5;
         k++;
         if (ph < DIV - 1) begin
            ec = ~(5'd1 << col);
            el = word(col);
`ifdef CURSOR_BLINK_EN
            if (((fr / BF) % 2) == 1 && int'(cc) == col && cc < 3'd5 && cl < 3'd7)
               el = el ^ (7'd1 << cl);
`endif
            ef = 1'b0;
         end else begin
            ec = 5'b11111; el = 7'd0; ef = (col == 4);
         end
      end
      #1;
      check("model_colunas", 32'(colunas), 32'(ec));
      check("model_linhas", 32'(linhas), 32'(el));
      check("model_fim", 32'(fim), 32'(ef));
      if (fim === 1'b1) fim_at.push_back(k);
      if (k > 0 && (k - 1) % DIV == 0) slot_cols.push_back(colunas);
   endtask

   task automatic run_cursor(input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2);
      logic [6:0] exp_f[6];
      exp_f = '{e0, e0, e1, e1, e2, e2};
      enable = 1'b0; step();
      enable = 1'b1;
      for (int f = 0; f < 6; f++) begin
         for (int s = 0; s < 5 * DIV; s++) begin
            step();
            if (s == 0) check("cursor_col0", 32'(linhas), 32'(exp_f[f]));
         end
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1;
      m0 = 7'b1110001; m1 = 7'b0100000; m2 = 7'd0; m3 = 7'd0; m4 = 7'b1110000;
      cc = 3'd0; cl = 3'd0;

      vec[0]  = '{1'b1, 1'b1, 5'b11111, 7'b0000000, 1'b0};
      vec[1]  = '{1'b1, 1'b1, 5'b11111, 7'b0000000, 1'b0};
      vec[2]  = '{1'b1, 1'b1, 5'b11111, 7'b0000000, 1'b0};
      vec[3]  = '{1'b0, 1'b1, 5'b11110, 7'b1110001, 1'b0};
      vec[4]  = '{1'b0, 1'b1, 5'b11110, 7'b1110001, 1'b0};
      vec[5]  = '{1'b0, 1'b1, 5'b11110, 7'b1110001, 1'b0};
      vec[6]  = '{1'b0, 1'b1, 5'b11111, 7'b0000000, 1'b0};
      vec[7]  = '{1'b0, 1'b1, 5'b11101, 7'b0100000, 1'b0};
      vec[8]  = '{1'b0, 1'b1, 5'b11101, 7'b0100000, 1'b0};
      vec[9]  = '{1'b0, 1'b1, 5'b11101, 7'b0100000, 1'b0};
      vec[10] = '{1'b0, 1'b1, 5'b11111, 7'b0000000, 1'b0};

      for (int i = 0; i < 11; i++) begin
         reset = vec[i].rst; enable = vec[i].en;
         step();
         check("vec_colunas", 32'(colunas), 32'(vec[i].col));
         check("vec_linhas", 32'(linhas), 32'(vec[i].lin));
         check("vec_fim", 32'(fim), 32'(vec[i].fim));
      end

      // Full frame: 40 enabled cycles in total since release
      for (int i = 0; i < 32; i++) step();
      check("frame_fim_count", 32'(fim_at.size()), 32'd2);
      if (fim_at.size() == 2) begin
         check("frame_fim_first", 32'(fim_at[0]), 32'd20);
         check("frame_fim_second", 32'(fim_at[1]), 32'd40);
      end
      check("frame_slot_count", 32'(slot_cols.size() >= 6), 32'd1);
      if (slot_cols.size() >= 6) begin
         check("slot1", 32'(slot_cols[0]), 32'(5'b11110));
         check("slot5", 32'(slot_cols[1]), 32'(5'b11101));
         check("slot9", 32'(slot_cols[2]), 32'(5'b11011));
         check("slot13", 32'(slot_cols[3]), 32'(5'b10111));
         check("slot17", 32'(slot_cols[4]), 32'(5'b01111));
         check("slot21", 32'(slot_cols[5]), 32'(5'b11110));
      end

      // Enable drop mid column 2
      for (int i = 0; i < 9; i++) step();
      check("drop_pre_col2", 32'(colunas), 32'(5'b11011));
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("drop_blank_col", 32'(colunas), 32'(5'b11111));
         check("drop_blank_lin", 32'(linhas), 32'd0);
      end
      enable = 1'b1;
      step();
      check("drop_restart", 32'(colunas), 32'(5'b11110));

      // Live update during column 0
      m0 = 7'b0000011;
      step();
      check("live_update", 32'(linhas), 32'(7'b0000011));
      m0 = 7'b1110001;

      // Cursor at (0,0), then out-of-range cursor
      cc = 3'd0; cl = 3'd0;
`ifdef CURSOR_BLINK_EN
      run_cursor(7'b1110001, 7'b1110000, 7'b1110001);
`else
      run_cursor(7'b1110001, 7'b1110001, 7'b1110001);
`endif
      cc = 3'd5;
      run_cursor(7'b1110001, 7'b1110001, 7'b1110001);

      // Randomized run against the scan model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) begin
            m0 = 7'($urandom); m1 = 7'($urandom); m2 = 7'($urandom);
            m3 = 7'($urandom); m4 = 7'($urandom);
         end
         if ($urandom_range(31) == 0) begin
            cc = 3'($urandom_range(7)); cl = 3'($urandom_range(7));
         end
         enable = ($urandom_range(63) != 0);
         reset  = ($urandom_range(199) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
